// File: rtl/pc_stack_counter.sv
// Program counter with return-address stack for the 8-bit CPU core.
// Latency: one cycle; the new pc is visible right after the enabled edge.
// Backpressure: none; enable=0 holds every register and suppresses wrap.
module pc_stack_counter #(
  parameter int ADDR_W      = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                jmp,
  input  logic [ADDR_W-1:0]   jmploc,
  input  logic                call,
  input  logic                ret,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W/2-1:0] pc_lo,
  output logic [ADDR_W/2-1:0] pc_hi,
  output logic [SP_W-1:0]     sp,
  output logic                stack_full,
  output logic                stack_empty,
  output logic                wrap,
  output logic                err
);

  localparam int              HALF     = ADDR_W / 2;
  localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);
  localparam logic [ADDR_W-1:0] PC_MAX = '1;

  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_wrap;
  logic              r_err;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_under;
  logic              w_push;
  logic              w_over;
  logic              w_jump;
  logic              w_inc;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [SP_W-1:0]   w_sp_top;
  logic [ADDR_W-1:0] w_top;

  // Action decode: ret beats call beats jmp; over/underflow fall back to a plain increment.
  always_comb begin
    w_full   = (r_sp == DEPTH_SP);
    w_empty  = (r_sp == '0);
    w_pop    = ret && !w_empty;
    w_under  = ret && w_empty;
    w_push   = !ret && call && !w_full;
    w_over   = !ret && call && w_full;
    w_jump   = !ret && !call && jmp;
    w_inc    = !(w_pop || w_push || w_jump);
    w_pc_inc = r_pc + ADDR_W'(1);
    w_sp_top = r_sp - SP_W'(1);
  end

  // Read mux for the stack top; written as a compare loop so the index width never has to match the array size.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (w_sp_top == SP_W'(i)) begin
        w_top = r_stack[i];
      end
    end
  end

  // PC, stack pointer and flag registers; reset overrides enable and every control input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= '0;
      r_sp   <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (enable) begin
      r_wrap <= w_inc && (r_pc == PC_MAX);
      r_err  <= r_err || w_under || w_over;
      if (w_pop) begin
        r_pc <= w_top;
        r_sp <= w_sp_top;
      end else if (w_push) begin
        r_pc <= jmploc;
        r_sp <= r_sp + SP_W'(1);
      end else if (w_jump) begin
        r_pc <= jmploc;
      end else begin
        r_pc <= w_pc_inc;
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Return-address storage; deliberately left uncleared by reset since sp=0 hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && enable && w_push) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (r_sp == SP_W'(i)) begin
          r_stack[i] <= w_pc_inc;
        end
      end
    end
  end

  assign pc          = r_pc;
  assign pc_lo       = r_pc[HALF-1:0];
  assign pc_hi       = r_pc[ADDR_W-1:HALF];
  assign sp          = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign wrap        = r_wrap;
  assign err         = r_err;

endmodule
